// File: rtl/rede_io_host.sv
// Host-side buffering for the rede processor I/O ports: per-port input FIFOs and one tagged output FIFO.
// Optional feature macro REDE_IO_STATUS_EN enables the saturating underflow/overflow counters.
module rede_io_host #(
    parameter int NUBITS = 31,
    parameter int NPORTS = 4,
    parameter int IDEPTH = 8,
    parameter int ODEPTH = 16,
    localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1,
    localparam int IAW = $clog2(IDEPTH),
    localparam int OAW = $clog2(ODEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [NUBITS-1:0] s_data,
    input  logic [PW-1:0]            s_port,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic signed [NUBITS-1:0] io_in,
    input  logic [NPORTS-1:0]        req_in,
    input  logic signed [NUBITS-1:0] io_out,
    input  logic [NPORTS-1:0]        out_en,
    output logic signed [NUBITS-1:0] m_data,
    output logic [PW-1:0]            m_port,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     underflow,
    output logic                     overflow,
    output logic                     multihot,
    output logic [15:0]              unf_cnt,
    output logic [15:0]              ovf_cnt
);

    typedef logic [IAW:0] iptr_t;
    typedef logic [OAW:0] optr_t;

    logic signed [NUBITS-1:0] imem_q [NPORTS][IDEPTH];
    iptr_t                    iwr_q [NPORTS];
    iptr_t                    iwr_d [NPORTS];
    iptr_t                    ird_q [NPORTS];
    iptr_t                    ird_d [NPORTS];
    logic signed [NUBITS-1:0] odat_q [ODEPTH];
    logic [PW-1:0]            oprt_q [ODEPTH];
    optr_t                    owr_q, owr_d, ord_q, ord_d;
    logic                     unf_q, unf_d, ovf_q, ovf_d, mh_q, mh_d;
    logic [NPORTS-1:0]        ifull, iempty;
    logic                     ofull, oempty;
    logic [PW-1:0]            rp, cp;
    logic                     push, pop, unf_evt, cap, drop, opop;

    function automatic logic [PW-1:0] lowest_idx(input logic [NPORTS-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (v[i]) idx = PW'(i);
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [NPORTS-1:0] v);
        return (v & (v - NPORTS'(1))) != '0;
    endfunction

    // Pointers are one bit wider than the address so full and empty stay distinguishable.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            iempty[p] = (iwr_q[p] == ird_q[p]);
            ifull[p]  = (iwr_q[p][IAW] != ird_q[p][IAW]) &&
                        (iwr_q[p][IAW-1:0] == ird_q[p][IAW-1:0]);
        end
    end

    assign oempty  = (owr_q == ord_q);
    assign ofull   = (owr_q[OAW] != ord_q[OAW]) && (owr_q[OAW-1:0] == ord_q[OAW-1:0]);
    assign rp      = lowest_idx(req_in);
    assign cp      = lowest_idx(out_en);

    assign s_ready = rst && !ifull[s_port];
    assign push    = s_valid && s_ready;
    assign pop     = rst && (req_in != '0) && !iempty[rp];
    assign unf_evt = rst && (req_in != '0) && iempty[rp];
    assign io_in   = pop ? imem_q[rp][ird_q[rp][IAW-1:0]] : '0;

    // A full output FIFO drops the capture even when the host pops on the same edge.
    assign cap     = rst && (out_en != '0) && !ofull;
    assign drop    = rst && (out_en != '0) && ofull;
    assign m_valid = !oempty;
    assign opop    = rst && m_valid && m_ready;
    assign m_data  = m_valid ? odat_q[ord_q[OAW-1:0]] : '0;
    assign m_port  = m_valid ? oprt_q[ord_q[OAW-1:0]] : '0;

    always_comb begin
        iwr_d = iwr_q;
        ird_d = ird_q;
        if (push) iwr_d[s_port] = iwr_q[s_port] + iptr_t'(1);
        if (pop)  ird_d[rp]     = ird_q[rp] + iptr_t'(1);
        owr_d = cap  ? owr_q + optr_t'(1) : owr_q;
        ord_d = opop ? ord_q + optr_t'(1) : ord_q;
        unf_d = unf_q | unf_evt;
        ovf_d = ovf_q | drop;
        mh_d  = mh_q | (rst && (multi_hot(req_in) || multi_hot(out_en)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                iwr_q[p] <= '0;
                ird_q[p] <= '0;
            end
            owr_q <= '0;
            ord_q <= '0;
            unf_q <= 1'b0;
            ovf_q <= 1'b0;
            mh_q  <= 1'b0;
        end else begin
            iwr_q <= iwr_d;
            ird_q <= ird_d;
            owr_q <= owr_d;
            ord_q <= ord_d;
            unf_q <= unf_d;
            ovf_q <= ovf_d;
            mh_q  <= mh_d;
        end
    end

    // Storage is never reset; emptied pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) imem_q[s_port][iwr_q[s_port][IAW-1:0]] <= s_data;
        if (cap) begin
            odat_q[owr_q[OAW-1:0]] <= io_out;
            oprt_q[owr_q[OAW-1:0]] <= cp;
        end
    end

    assign underflow = unf_q;
    assign overflow  = ovf_q;
    assign multihot  = mh_q;

`ifdef REDE_IO_STATUS_EN
    logic [15:0] unf_cnt_q, ovf_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            unf_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            if (unf_evt) unf_cnt_q <= sat_inc(unf_cnt_q);
            if (drop)    ovf_cnt_q <= sat_inc(ovf_cnt_q);
        end
    end

    assign unf_cnt = unf_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`else
    assign unf_cnt = '0;
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_rede_io_host.sv
// Self-checking bench for rede_io_host: queue-based reference model plus directed literal checks.
// Counter expectations follow REDE_IO_STATUS_EN when it is defined for the build.
module tb_rede_io_host;
    localparam int IDEPTH = 8;
    localparam int ODEPTH = 16;

    typedef logic signed [30:0] word_t;
    typedef struct packed {
        logic [1:0] p;
        word_t      d;
    } oent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    word_t       s_data = '0;
    logic [1:0]  s_port = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    word_t       io_in;
    logic [3:0]  req_in = '0;
    word_t       io_out = '0;
    logic [3:0]  out_en = '0;
    word_t       m_data;
    logic [1:0]  m_port;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        underflow, overflow, multihot;
    logic [15:0] unf_cnt, ovf_cnt;

    rede_io_host #(.NUBITS(31), .NPORTS(4), .IDEPTH(IDEPTH), .ODEPTH(ODEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_port(s_port), .s_valid(s_valid), .s_ready(s_ready),
        .io_in(io_in), .req_in(req_in), .io_out(io_out), .out_en(out_en),
        .m_data(m_data), .m_port(m_port), .m_valid(m_valid), .m_ready(m_ready),
        .underflow(underflow), .overflow(overflow), .multihot(multihot),
        .unf_cnt(unf_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Reference model: plain queues, updated on each rising edge from the sampled inputs.
    word_t iq[4][$];
    oent_t oq[$];
    bit    m_unf, m_ovf, m_mh;
    int    m_unfc, m_ovfc;
    int    mp;
    bit    push_ok, cap_ok;

    always @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) iq[p].delete();
            oq.delete();
            m_unf = 0; m_ovf = 0; m_mh = 0; m_unfc = 0; m_ovfc = 0;
        end else begin
            push_ok = s_valid && (iq[s_port].size() < IDEPTH);
            cap_ok  = (out_en != 0) && (oq.size() < ODEPTH);
            if (req_in != 0) begin
                mp = lowest(req_in);
                if (iq[mp].size() == 0) begin
                    m_unf = 1;
                    if (m_unfc < 65535) m_unfc++;
                end else begin
                    void'(iq[mp].pop_front());
                end
            end
            if ((out_en != 0) && !cap_ok) begin
                m_ovf = 1;
                if (m_ovfc < 65535) m_ovfc++;
            end
            if ($countones(req_in) > 1 || $countones(out_en) > 1) m_mh = 1;
            if (push_ok) iq[s_port].push_back(s_data);
            if (oq.size() > 0 && m_ready) void'(oq.pop_front());
            if (cap_ok) oq.push_back('{p: 2'(lowest(out_en)), d: io_out});
        end
    end

    word_t e_io, e_md;
    logic [1:0] e_mp;
    int e_uc, e_oc;

    always @(negedge clk) begin
        if (chk_en) begin
            e_io = '0;
            if (rst && req_in != 0 && iq[lowest(req_in)].size() > 0) e_io = iq[lowest(req_in)][0];
            e_md = '0;
            e_mp = '0;
            if (oq.size() > 0) begin
                e_md = oq[0].d;
                e_mp = oq[0].p;
            end
`ifdef REDE_IO_STATUS_EN
            e_uc = m_unfc;
            e_oc = m_ovfc;
`else
            e_uc = 0;
            e_oc = 0;
`endif
            chk("io_in", 32'(io_in), 32'(e_io));
            chk("s_ready", 32'(s_ready), 32'(rst && (iq[s_port].size() < IDEPTH)));
            chk("m_valid", 32'(m_valid), 32'(oq.size() > 0));
            chk("m_data", 32'(m_data), 32'(e_md));
            chk("m_port", 32'(m_port), 32'(e_mp));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("multihot", 32'(multihot), 32'(m_mh));
            chk("unf_cnt", 32'(unf_cnt), 32'(e_uc));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(e_oc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    word_t neg5;
    int    r;

    initial begin
        neg5 = -31'sd5;
        repeat (2) tick();
        chk("s_ready_in_reset", 32'(s_ready), 32'd0);
        rst = 1'b1;
        chk_en = 1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_flags", {29'd0, underflow, overflow, multihot}, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // Fill and drain port 2
        s_port = 2; s_valid = 1;
        s_data = 31'h11; tick();
        s_data = 31'h22; tick();
        s_data = 31'h33; tick();
        s_valid = 0; req_in = 4'b0100;
        #1 chk("p2_word0", 32'(io_in), 32'h11); tick();
        #1 chk("p2_word1", 32'(io_in), 32'h22); tick();
        #1 chk("p2_word2", 32'(io_in), 32'h33); tick();
        req_in = 0;
        chk("p2_no_underflow", 32'(underflow), 32'd0);

        // Full and empty boundaries on port 0
        s_port = 0; s_valid = 1;
        for (int k = 0; k < 9; k++) begin
            s_data = word_t'(100 + k);
            #1;
            if (k == 7) chk("p0_ready_at7", 32'(s_ready), 32'd1);
            if (k == 8) chk("p0_ready_full", 32'(s_ready), 32'd0);
            tick();
        end
        s_valid = 0; req_in = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1 chk("p0_drain", 32'(io_in), 32'(100 + k));
            tick();
        end
        #1 chk("p0_underflow_io", 32'(io_in), 32'd0);
        tick();
        req_in = 0;
        chk("p0_underflow_flag", 32'(underflow), 32'd1);
`ifdef REDE_IO_STATUS_EN
        chk("p0_unf_cnt", 32'(unf_cnt), 32'd1);
`else
        chk("p0_unf_cnt", 32'(unf_cnt), 32'd0);
`endif
        rst = 0; tick(); rst = 1;

        // Output order under back-pressure
        m_ready = 0;
        out_en = 4'b1000; io_out = neg5; tick();
        out_en = 4'b0010; io_out = 31'sd7; tick();
        out_en = 0;
        #1;
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_port0", 32'(m_port), 32'd3);
        chk("bp_data0", 32'(m_data), 32'(neg5));
        m_ready = 1; tick();
        #1;
        chk("bp_port1", 32'(m_port), 32'd1);
        chk("bp_data1", 32'(m_data), 32'd7);
        tick();
        #1 chk("bp_empty", 32'(m_valid), 32'd0);
        m_ready = 0;

        // Output overflow: 17 captures into 16 slots
        for (int k = 0; k < 17; k++) begin
            out_en = 4'b0001 << (k % 4);
            io_out = word_t'(k);
            tick();
        end
        out_en = 0;
        chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef REDE_IO_STATUS_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
        m_ready = 1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("ovf_drain_data", 32'(m_data), 32'(k));
            chk("ovf_drain_port", 32'(m_port), 32'(k % 4));
            tick();
        end
        #1 chk("ovf_drained", 32'(m_valid), 32'd0);
        m_ready = 0;

        // Multi-hot request and same-cycle push/pop on an empty port
        s_port = 1; s_valid = 1; s_data = 31'h55; tick();
        s_valid = 0;
        chk("mh_before", 32'(multihot), 32'd0);
        req_in = 4'b0110;
        #1 chk("mh_serve_p1", 32'(io_in), 32'h55);
        tick();
        req_in = 0;
        chk("mh_flag", 32'(multihot), 32'd1);
        s_port = 3; s_valid = 1; s_data = 31'h77; req_in = 4'b1000;
        #1 chk("nobypass_io", 32'(io_in), 32'd0);
        tick();
        s_valid = 0;
        #1 chk("nobypass_next", 32'(io_in), 32'h77);
        tick();
        req_in = 0;

        // Reset mid-stream
        s_port = 0; s_valid = 1; s_data = 31'd5; out_en = 4'b0001; io_out = 31'd9;
        tick(); tick();
        s_valid = 0; out_en = 0;
        #1 chk("mid_m_valid_pre", 32'(m_valid), 32'd1);
        rst = 0; tick(); rst = 1;
        #1;
        chk("mid_m_valid", 32'(m_valid), 32'd0);
        chk("mid_m_data", 32'(m_data), 32'd0);
        chk("mid_flags", {29'd0, underflow, overflow, multihot}, 32'd0);
        req_in = 4'b0001;
        #1 chk("mid_io_in", 32'(io_in), 32'd0);
        tick();
        req_in = 0;

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            s_valid = $urandom_range(0, 1);
            s_port  = 2'($urandom);
            s_data  = word_t'($urandom);
            io_out  = word_t'($urandom);
            r = $urandom_range(0, 9);
            if (((i / 500) % 2) == 0)
                req_in = (r < 7) ? 4'b0 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            else
                req_in = (r < 2) ? 4'b0 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            r = $urandom_range(0, 9);
            out_en  = (r < 4) ? 4'b0 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            m_ready = (((i / 500) % 2) == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end

        rst = 1; s_valid = 0; req_in = 0; out_en = 0; m_ready = 0;
        tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
